// File: rtl/isr_host_port.sv
// isr_host_port: host-side initiator for the ip_send_recv byte interface.
// On start it serializes the 128-bit key (MSB byte first) and then the
// address table (entry 0..N-1, MSB byte first) onto the 8-bit device bus.
// After that it forwards upstream packet bytes while the device is not busy.
// Independently, it gathers device output bytes into 128-bit blocks and
// compares each completed block against exp_in.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start               restart pulse; latches key_in
//   key_in              AES key, [127:120] sent first
//   addr_wr/idx/in      address table write port (IDLE only)
//   pkt_valid/data      upstream packet byte source
//   pkt_ready           upstream handshake (STREAM and not busy)
//   dev_in              registered byte to the device
//   key_enable          dev_in carries a key byte
//   address_enable      dev_in carries an address byte
//   ready               dev_in carries a packet byte
//   busy                device cannot take packet bytes
//   done/out            device output byte strobe and data
//   exp_in              expected block value
//   cfg_done            high while streaming
//   blk_valid/data      completed block pulse and data
//   blk_match           completed block equals exp_in
//   blk_cnt             blocks completed since last start
module isr_host_port #(
  parameter int unsigned KEY_BYTES    = 16,
  parameter int unsigned ADDR_ENTRIES = 8,
  parameter int unsigned ADDR_BYTES   = 4,
  parameter int unsigned BLK_BYTES    = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         addr_wr,
  input  logic [2:0]   addr_idx,
  input  logic [31:0]  addr_in,
  input  logic         pkt_valid,
  input  logic [7:0]   pkt_data,
  output logic         pkt_ready,
  output logic [7:0]   dev_in,
  output logic         key_enable,
  output logic         address_enable,
  output logic         ready,
  input  logic         busy,
  input  logic         done,
  input  logic [7:0]   out,
  input  logic [127:0] exp_in,
  output logic         cfg_done,
  output logic         blk_valid,
  output logic [127:0] blk_data,
  output logic         blk_match,
  output logic [15:0]  blk_cnt
);

  localparam int unsigned CW        = 6;
  localparam int unsigned AW        = $clog2(ADDR_ENTRIES);
  localparam int unsigned KEY_LAST  = KEY_BYTES - 1;
  localparam int unsigned ADDR_LAST = ADDR_ENTRIES * ADDR_BYTES - 1;
  localparam int unsigned BLK_LAST  = BLK_BYTES - 1;

  typedef enum logic [1:0] {IDLE, KEY, ADDR, STREAM} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [127:0]   key_sr_q, key_sr_d;
  logic [31:0]    tbl_q [ADDR_ENTRIES];
  logic [7:0]     dev_in_q, dev_in_d;
  logic           key_en_q, key_en_d;
  logic           addr_en_q, addr_en_d;
  logic           ready_q, ready_d;
  logic [31:0]    ent_word;
  logic [7:0]     addr_byte;

  // Collector only ever holds up to BLK_BYTES-1 bytes; the last byte is
  // appended on the fly when the block completes.
  logic [119:0]   col_sr_q, col_sr_d;
  logic [3:0]     col_cnt_q, col_cnt_d;
  logic [127:0]   col_next;
  logic           blk_valid_q, blk_valid_d;
  logic [127:0]   blk_data_q, blk_data_d;
  logic           blk_match_q, blk_match_d;
  logic [15:0]    blk_cnt_q, blk_cnt_d;

  always_comb begin
    ent_word  = tbl_q[AW'(cnt_q / CW'(ADDR_BYTES))];
    addr_byte = '0;
    for (int unsigned b = 0; b < ADDR_BYTES; b++) begin
      if ((cnt_q % CW'(ADDR_BYTES)) == CW'(b)) addr_byte = ent_word[(ADDR_BYTES-1-b)*8 +: 8];
    end
  end

  // Sequencer. The first key byte is emitted in the start cycle itself, so
  // key_enable rises the cycle right after start; KEY then sends the rest.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    key_sr_d  = key_sr_q;
    dev_in_d  = dev_in_q;
    key_en_d  = 1'b0;
    addr_en_d = 1'b0;
    ready_d   = 1'b0;
    if (start) begin
      state_d  = KEY;
      key_sr_d = {key_in[119:0], 8'h00};
      dev_in_d = key_in[127:120];
      key_en_d = 1'b1;
      cnt_d    = CW'(1);
    end else begin
      case (state_q)
        KEY: begin
          dev_in_d = key_sr_q[127:120];
          key_en_d = 1'b1;
          key_sr_d = {key_sr_q[119:0], 8'h00};
          if (cnt_q == CW'(KEY_LAST)) begin
            state_d = ADDR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ADDR: begin
          dev_in_d  = addr_byte;
          addr_en_d = 1'b1;
          if (cnt_q == CW'(ADDR_LAST)) begin
            state_d = STREAM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        STREAM: begin
          if (pkt_valid && !busy) begin
            dev_in_d = pkt_data;
            ready_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    col_next    = {col_sr_q, out};
    col_sr_d    = col_sr_q;
    col_cnt_d   = col_cnt_q;
    blk_valid_d = 1'b0;
    blk_data_d  = blk_data_q;
    blk_match_d = blk_match_q;
    blk_cnt_d   = blk_cnt_q;
    if (start) begin
      col_sr_d  = '0;
      col_cnt_d = '0;
      blk_cnt_d = '0;
    end else if (done) begin
      col_cnt_d = col_cnt_q + 4'd1;
      if (col_cnt_q == 4'(BLK_LAST)) begin
        blk_valid_d = 1'b1;
        blk_data_d  = col_next;
        blk_match_d = (col_next == exp_in);
        blk_cnt_d   = blk_cnt_q + 16'd1;
        col_sr_d    = '0;
      end else begin
        col_sr_d = col_next[119:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      key_sr_q    <= '0;
      dev_in_q    <= '0;
      key_en_q    <= 1'b0;
      addr_en_q   <= 1'b0;
      ready_q     <= 1'b0;
      col_sr_q    <= '0;
      col_cnt_q   <= '0;
      blk_valid_q <= 1'b0;
      blk_data_q  <= '0;
      blk_match_q <= 1'b0;
      blk_cnt_q   <= '0;
      for (int unsigned i = 0; i < ADDR_ENTRIES; i++) tbl_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_sr_q    <= key_sr_d;
      dev_in_q    <= dev_in_d;
      key_en_q    <= key_en_d;
      addr_en_q   <= addr_en_d;
      ready_q     <= ready_d;
      col_sr_q    <= col_sr_d;
      col_cnt_q   <= col_cnt_d;
      blk_valid_q <= blk_valid_d;
      blk_data_q  <= blk_data_d;
      blk_match_q <= blk_match_d;
      blk_cnt_q   <= blk_cnt_d;
      if (state_q == IDLE && addr_wr) tbl_q[addr_idx] <= addr_in;
    end
  end

  // Start suppresses the handshake so a pending upstream byte is not consumed.
  assign pkt_ready      = (state_q == STREAM) && !busy && !start;
  assign cfg_done       = (state_q == STREAM);
  assign dev_in         = dev_in_q;
  assign key_enable     = key_en_q;
  assign address_enable = addr_en_q;
  assign ready          = ready_q;
  assign blk_valid      = blk_valid_q;
  assign blk_data       = blk_data_q;
  assign blk_match      = blk_match_q;
  assign blk_cnt        = blk_cnt_q;

endmodule

// File: tb/tb_isr_host_port.sv
module tb_isr_host_port;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         addr_wr;
  logic [2:0]   addr_idx;
  logic [31:0]  addr_in;
  logic         pkt_valid;
  logic [7:0]   pkt_data;
  logic         pkt_ready;
  logic [7:0]   dev_in;
  logic         key_enable;
  logic         address_enable;
  logic         ready;
  logic         busy;
  logic         done;
  logic [7:0]   out;
  logic [127:0] exp_in;
  logic         cfg_done;
  logic         blk_valid;
  logic [127:0] blk_data;
  logic         blk_match;
  logic [15:0]  blk_cnt;

  int n_vec  = 0;
  int n_fail = 0;
  logic [31:0] tbl_m [8];

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       b;
    logic       exp_prdy;
    logic       exp_rdy;
    logic [7:0] exp_dev;
  } svec_t;
  svec_t sv [7];

  isr_host_port #(
    .KEY_BYTES   (16),
    .ADDR_ENTRIES(8),
    .ADDR_BYTES  (4),
    .BLK_BYTES   (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .key_in        (key_in),
    .addr_wr       (addr_wr),
    .addr_idx      (addr_idx),
    .addr_in       (addr_in),
    .pkt_valid     (pkt_valid),
    .pkt_data      (pkt_data),
    .pkt_ready     (pkt_ready),
    .dev_in        (dev_in),
    .key_enable    (key_enable),
    .address_enable(address_enable),
    .ready         (ready),
    .busy          (busy),
    .done          (done),
    .out           (out),
    .exp_in        (exp_in),
    .cfg_done      (cfg_done),
    .blk_valid     (blk_valid),
    .blk_data      (blk_data),
    .blk_match     (blk_match),
    .blk_cnt       (blk_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dev_in"}, 128'(dev_in), 0);
    chk({tag, "_key_en"}, 128'(key_enable), 0);
    chk({tag, "_addr_en"}, 128'(address_enable), 0);
    chk({tag, "_ready"}, 128'(ready), 0);
    chk({tag, "_cfg_done"}, 128'(cfg_done), 0);
    chk({tag, "_pkt_ready"}, 128'(pkt_ready), 0);
    chk({tag, "_blk_valid"}, 128'(blk_valid), 0);
    chk({tag, "_blk_data"}, blk_data, 0);
    chk({tag, "_blk_match"}, 128'(blk_match), 0);
    chk({tag, "_blk_cnt"}, 128'(blk_cnt), 0);
  endtask

  // Starts a configuration load and checks the first n bytes on the bus.
  task automatic cfg_seq(input logic [127:0] key, input int n, input bit drop_done);
    logic [127:0] kt;
    logic [31:0]  w;
    start  = 1'b1;
    key_in = key;
    if (drop_done) begin
      done = 1'b1;
      out  = 8'hee;
    end
    #1;
    chk("pkt_ready_at_start", 128'(pkt_ready), 0);
    step();
    start     = 1'b0;
    done      = 1'b0;
    pkt_valid = 1'b0;
    chk("blk_cnt_after_start", 128'(blk_cnt), 0);
    for (int i = 0; i < n; i++) begin
      if (i > 0) step();
      if (i < 16) begin
        kt = key << (8 * i);
        chk($sformatf("key_en[%0d]", i), 128'(key_enable), 1);
        chk($sformatf("addr_en[%0d]", i), 128'(address_enable), 0);
        chk($sformatf("key_byte[%0d]", i), 128'(dev_in), 128'(kt[127:120]));
      end else begin
        w = tbl_m[(i - 16) / 4] << (8 * ((i - 16) % 4));
        chk($sformatf("key_en[%0d]", i), 128'(key_enable), 0);
        chk($sformatf("addr_en[%0d]", i), 128'(address_enable), 1);
        chk($sformatf("addr_byte[%0d]", i), 128'(dev_in), 128'(w[31:24]));
      end
      chk($sformatf("cfg_ready[%0d]", i), 128'(ready), 0);
      chk($sformatf("cfg_done[%0d]", i), 128'(cfg_done), (i == 47) ? 128'd1 : 128'd0);
    end
    if (n == 48) begin
      step();
      chk("stream_cfg_done", 128'(cfg_done), 1);
      chk("stream_key_en", 128'(key_enable), 0);
      chk("stream_addr_en", 128'(address_enable), 0);
    end
  endtask

  task automatic send_block(input logic [127:0] blk, input logic [15:0] exp_cnt, input logic exp_match);
    logic [127:0] bt;
    for (int k = 0; k < 16; k++) begin
      bt   = blk << (8 * k);
      done = 1'b1;
      out  = bt[127:120];
      step();
      if (k < 15) begin
        chk($sformatf("blk_valid_early[%0d]", k), 128'(blk_valid), 0);
      end else begin
        chk("blk_valid", 128'(blk_valid), 1);
        chk("blk_data", blk_data, blk);
        chk("blk_match", 128'(blk_match), 128'(exp_match));
        chk("blk_cnt", 128'(blk_cnt), 128'(exp_cnt));
      end
    end
    done = 1'b0;
    step();
    chk("blk_valid_one_cycle", 128'(blk_valid), 0);
    chk("blk_data_hold", blk_data, blk);
  endtask

  initial begin
    logic [127:0] blk1, blk2, c1, c2, blkb;
    logic [7:0]   cb;
    int           rdy_seen;

    sv[0] = '{1'b1, 8'h61, 1'b0, 1'b1, 1'b1, 8'h61};
    sv[1] = '{1'b1, 8'hca, 1'b1, 1'b0, 1'b0, 8'h61};
    sv[2] = '{1'b1, 8'hca, 1'b0, 1'b1, 1'b1, 8'hca};
    sv[3] = '{1'b1, 8'h9b, 1'b0, 1'b1, 1'b1, 8'h9b};
    sv[4] = '{1'b1, 8'hbf, 1'b0, 1'b1, 1'b1, 8'hbf};
    sv[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hbf};
    sv[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hbf};

    rst = 1'b0; start = 1'b0; key_in = '0; addr_wr = 1'b0; addr_idx = '0; addr_in = '0;
    pkt_valid = 1'b0; pkt_data = '0; busy = 1'b0; done = 1'b0; out = '0; exp_in = '0;
    for (int i = 0; i < 8; i++) tbl_m[i] = '0;

    #12;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    step();

    addr_wr = 1'b1; addr_idx = 3'd0; addr_in = 32'ha761ca9b;
    step();
    addr_idx = 3'd4; addr_in = 32'h43c97381;
    step();
    addr_wr = 1'b0;
    tbl_m[0] = 32'ha761ca9b;
    tbl_m[4] = 32'h43c97381;

    cfg_seq(128'h000102030405060708090a0b0c0d0e0f, 48, 1'b0);

    // addr_wr outside IDLE must not alter the table
    addr_wr = 1'b1; addr_idx = 3'd1; addr_in = 32'hdeadbeef;
    step();
    addr_wr = 1'b0;

    rdy_seen = 0;
    for (int k = 0; k < 7; k++) begin
      pkt_valid = sv[k].v;
      pkt_data  = sv[k].d;
      busy      = sv[k].b;
      #1;
      chk($sformatf("pkt_ready[%0d]", k), 128'(pkt_ready), 128'(sv[k].exp_prdy));
      step();
      if (ready) rdy_seen++;
      chk($sformatf("ready[%0d]", k), 128'(ready), 128'(sv[k].exp_rdy));
      chk($sformatf("pkt_dev_in[%0d]", k), 128'(dev_in), 128'(sv[k].exp_dev));
    end
    pkt_valid = 1'b0;
    busy      = 1'b0;
    chk("ready_count", 128'(rdy_seen), 4);

    blk1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    blk2   = 128'h69c4e0d86a7b0430d8cdb78070b4c55b;
    exp_in = blk1;
    send_block(blk1, 16'd1, 1'b1);
    send_block(blk2, 16'd2, 1'b0);

    c1 = '0;
    c2 = '0;
    for (int k = 0; k < 32; k++) begin
      cb = 8'(k * 13 + 7);
      if (k < 16) c1 = {c1[119:0], cb};
      else        c2 = {c2[119:0], cb};
    end
    exp_in = c1;
    for (int k = 0; k < 32; k++) begin
      cb   = 8'(k * 13 + 7);
      done = 1'b1;
      out  = cb;
      step();
      if (k == 15) begin
        chk("cont_valid1", 128'(blk_valid), 1);
        chk("cont_data1", blk_data, c1);
        chk("cont_match1", 128'(blk_match), 1);
        chk("cont_cnt1", 128'(blk_cnt), 3);
      end else if (k == 31) begin
        chk("cont_valid2", 128'(blk_valid), 1);
        chk("cont_data2", blk_data, c2);
        chk("cont_match2", 128'(blk_match), 0);
        chk("cont_cnt2", 128'(blk_cnt), 4);
      end else begin
        chk($sformatf("cont_valid_idle[%0d]", k), 128'(blk_valid), 0);
      end
    end
    done = 1'b0;

    // partial block pending, then start with a done byte in the same cycle
    for (int k = 0; k < 3; k++) begin
      done = 1'b1;
      out  = 8'(8'h11 * (k + 1));
      step();
    end
    done      = 1'b0;
    pkt_valid = 1'b1;
    pkt_data  = 8'h5a;
    busy      = 1'b0;
    cfg_seq(128'hf0e1d2c3b4a5968778695a4b3c2d1e0f, 48, 1'b1);
    blkb   = 128'h0123456789abcdeffedcba9876543210;
    exp_in = blkb;
    send_block(blkb, 16'd1, 1'b1);

    // reset during ADDR byte 10, then a replay with a cleared table
    cfg_seq(128'h11223344556677889900aabbccddeeff, 27, 1'b0);
    rst = 1'b0;
    #1;
    chk_zero("rst_async");
    for (int i = 0; i < 8; i++) tbl_m[i] = '0;
    @(negedge clk);
    rst = 1'b1;
    step();
    cfg_seq(128'h11223344556677889900aabbccddeeff, 48, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
